cache_refill: RTL

Miss-handling and refill controller for the 4-set direct-mapped data cache (4 words/block, 26-bit tag, set = A[5:4], word = A[3:2]). It watches the cache `Hit` output for each valid access and, on a miss, stalls the pipeline. It then reads the four words of the missing block from main data memory one at a time and presents them on `d0`..`d3` with a one-cycle `fill_en` strobe, which is the cache's write enable. It sits between the cache and the data-memory port and feeds the cache's fill inputs.

---
 rtl/cache_refill.sv | 103 ++++++++++
 1 files changed

// File: rtl/cache_refill.sv
// Miss-handling / refill controller for a 4-set direct-mapped data cache.
// On a miss, stalls the pipeline, reads the 4-word block word by word and strobes it into the cache.
module cache_refill #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic                  Hit,
  output logic                  stall,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  fill_en,
  output logic [DATA_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  output logic [DATA_WIDTH-1:0] d3,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] FILL  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]                       state_q, state_d;
  logic [1:0]                       cnt_q, cnt_d;
  logic [DATA_WIDTH-5:0]            base_q, base_d;
  logic [3:0][DATA_WIDTH-1:0]       word_q, word_d;
  logic [CNT_WIDTH-1:0]             miss_q, miss_d;
  logic                             miss;

  assign miss = (state_q == IDLE) & req & ~Hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    word_d  = word_q;
    miss_d  = miss_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          base_d  = A[DATA_WIDTH-1:4];
          cnt_d   = 2'd0;
          if (miss_q != '1) miss_d = miss_q + CNT_ONE;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // rvalid is only honoured here; strays in other states are dropped
        if (mem_rvalid) begin
          word_d[cnt_q] = mem_rdata;
          if (cnt_q == 2'd3) begin
            state_d = FILL;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            state_d = ISSUE;
          end
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      base_q  <= '0;
      word_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      word_q  <= word_d;
      miss_q  <= miss_d;
    end
  end

  // Stall is combinational so the missing access is held in the cycle it misses.
  assign stall      = miss | (state_q != IDLE);
  assign mem_rd_en  = (state_q == ISSUE);
  assign mem_addr   = mem_rd_en ? {base_q, cnt_q, 2'b00} : '0;
  assign fill_en    = (state_q == FILL);
  assign fill_addr  = fill_en ? {base_q, 4'b0000} : '0;
  assign d0         = word_q[0];
  assign d1         = word_q[1];
  assign d2         = word_q[2];
  assign d3         = word_q[3];
  assign miss_count = miss_q;

endmodule
